// File: rtl/noc_pkg.sv
// Shared types and constants for the 5-port mesh router.
// Port order is fixed N, S, E, W, L so that indices can double as directions.
package noc_pkg;

  localparam int NPORT = 5;
  localparam int PW    = 3;

  typedef enum logic [PW-1:0] {
    N = 3'd0,
    S = 3'd1,
    E = 3'd2,
    W = 3'd3,
    L = 3'd4
  } port_e;

  // Round-robin successor: wraps from the last port back to N.
  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
    return (idx >= PW'(NPORT - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/switch_alloc_rr_arb5.sv
// Combinational 5-way round-robin arbiter: first requester at or after the
// pointer wins, searching upward and wrapping from L back to N.
module rr_arb5
  import noc_pkg::*;
(
  input  logic [NPORT-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [NPORT-1:0] o_gnt,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    logic [PW-1:0] c;
    // NOTE: every output gets a default before the search loop; a path that
    // left one unassigned would infer a latch instead of combinational logic.
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    c     = '0;
    for (int k = 0; k < NPORT; k++) begin
      c = PW'((int'(i_ptr) + k) % NPORT);
      if (!o_any && i_req[c]) begin
        o_gnt[c] = 1'b1;
        o_idx    = c;
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_alloc.sv
// Wormhole switch allocator: round-robin per output, grant held from head
// flit until the tail crosses; drives queue pops and crossbar selects.
module switch_alloc #(
  parameter int NPORT = noc_pkg::NPORT,
  parameter int PW    = noc_pkg::PW
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NPORT-1:0]          in_valid_i,
  input  logic [NPORT-1:0]          in_tail_i,
  input  logic [NPORT-1:0][PW-1:0]  req_port_i,
  input  logic [NPORT-1:0]          out_ready_i,
  output logic [NPORT-1:0]          in_pop_o,
  output logic [NPORT-1:0]          out_valid_o,
  output logic [NPORT-1:0][PW-1:0]  out_sel_o,
  output logic                      err_o
);

  // Per-output state
  logic [NPORT-1:0]          r_locked;
  logic [NPORT-1:0][PW-1:0]  r_owner;
  logic [NPORT-1:0][PW-1:0]  r_rr_ptr;
  // Per-input state
  logic [NPORT-1:0]          r_bound;
  logic [NPORT-1:0][PW-1:0]  r_dest;
  logic                      r_err;

  logic [NPORT-1:0][NPORT-1:0] w_idle_req;
  logic [NPORT-1:0]            w_bad;
  logic [NPORT-1:0][NPORT-1:0] w_arb_gnt;
  logic [NPORT-1:0][PW-1:0]    w_arb_idx;
  logic [NPORT-1:0]            w_arb_any;
  logic [NPORT-1:0][NPORT-1:0] w_win_oh;
  logic [NPORT-1:0][PW-1:0]    w_win_idx;
  logic [NPORT-1:0]            w_win_ok;
  logic [NPORT-1:0]            w_win_tail;
  logic [NPORT-1:0]            w_xfer;
  logic [NPORT-1:0]            w_bind_set;
  logic [NPORT-1:0]            w_bind_clr;
  logic [NPORT-1:0][PW-1:0]    w_dest_nxt;

  // Only unbound, valid inputs with an in-range port compete for idle outputs;
  // a bound input's live request is its stored destination, handled by the lock.
  always_comb begin
    w_idle_req = '0;
    w_bad      = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (in_valid_i[i] && !r_bound[i]) begin
        if (req_port_i[i] >= PW'(NPORT)) begin
          w_bad[i] = 1'b1;
        end else begin
          for (int o = 0; o < NPORT; o++) begin
            if (req_port_i[i] == PW'(o)) w_idle_req[o][i] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arb5 u_arb (
      .i_req (w_idle_req[o]),
      .i_ptr (r_rr_ptr[o]),
      .o_gnt (w_arb_gnt[o]),
      .o_idx (w_arb_idx[o]),
      .o_any (w_arb_any[o])
    );
  end

  // A locked output ignores the arbiter and waits on its owner's queue.
  always_comb begin
    w_win_oh   = '0;
    w_win_idx  = '0;
    w_win_ok   = '0;
    w_win_tail = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (r_locked[o]) begin
        for (int i = 0; i < NPORT; i++) begin
          w_win_oh[o][i] = (r_owner[o] == PW'(i));
        end
        w_win_idx[o] = r_owner[o];
        w_win_ok[o]  = |(w_win_oh[o] & in_valid_i);
      end else begin
        w_win_oh[o]  = w_arb_gnt[o];
        w_win_idx[o] = w_arb_idx[o];
        w_win_ok[o]  = w_arb_any[o];
      end
      w_win_tail[o] = |(w_win_oh[o] & in_tail_i);
    end
  end

  // Outputs are gated by reset so nothing crosses while the router is held.
  assign w_xfer = w_win_ok & out_ready_i & {NPORT{rst_n_i}};

  always_comb begin
    in_pop_o    = '0;
    out_valid_o = '0;
    out_sel_o   = '0;
    w_bind_set  = '0;
    w_bind_clr  = '0;
    w_dest_nxt  = r_dest;
    for (int o = 0; o < NPORT; o++) begin
      if (w_xfer[o]) begin
        in_pop_o       = in_pop_o | w_win_oh[o];
        out_valid_o[o] = 1'b1;
        out_sel_o[o]   = w_win_idx[o];
        if (!r_locked[o] && !w_win_tail[o]) begin
          w_bind_set = w_bind_set | w_win_oh[o];
          for (int i = 0; i < NPORT; i++) begin
            if (w_win_oh[o][i]) w_dest_nxt[i] = PW'(o);
          end
        end else if (r_locked[o] && w_win_tail[o]) begin
          w_bind_clr = w_bind_clr | w_win_oh[o];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_locked <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_bound  <= '0;
      r_dest   <= '0;
      r_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on the
      // pre-edge state, so per-output and per-input updates never race.
      for (int o = 0; o < NPORT; o++) begin
        if (w_xfer[o]) begin
          if (!r_locked[o]) begin
            r_rr_ptr[o] <= noc_pkg::rr_next(w_win_idx[o]);
            if (!w_win_tail[o]) begin
              r_locked[o] <= 1'b1;
              r_owner[o]  <= w_win_idx[o];
            end
          end else if (w_win_tail[o]) begin
            r_locked[o] <= 1'b0;
          end
        end
      end
      r_bound <= (r_bound & ~w_bind_clr) | w_bind_set;
      r_dest  <= w_dest_nxt;
      if (|w_bad) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_switch_alloc.sv
// Bench for switch_alloc: directed scenarios plus random traffic, all checked
// against a packet-level allocator model held in the bench.
module tb_switch_alloc;
  import noc_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic [4:0]       in_valid_i = '0;
  logic [4:0]       in_tail_i = '0;
  logic [4:0][2:0]  req_port_i = '0;
  logic [4:0]       out_ready_i = '0;
  logic [4:0]       in_pop_o;
  logic [4:0]       out_valid_o;
  logic [4:0][2:0]  out_sel_o;
  logic             err_o;

  typedef struct packed {
    logic [4:0]      pop;
    logic [4:0]      vld;
    logic [4:0][2:0] sel;
    logic            err;
  } smp_t;

  int n_vec = 0;
  int n_err = 0;

  // Model: owner input per output (-1 idle), destination per input (-1 free).
  int m_owner [5];
  int m_dest  [5];
  int m_rr    [5];
  bit m_err;

  switch_alloc dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_tail_i   (in_tail_i),
    .req_port_i  (req_port_i),
    .out_ready_i (out_ready_i),
    .in_pop_o    (in_pop_o),
    .out_valid_o (out_valid_o),
    .out_sel_o   (out_sel_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_owner[i] = -1;
      m_dest[i]  = -1;
      m_rr[i]    = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic void report(string name, smp_t o, smp_t e);
    $display("FAIL %s @%0t: got pop=%b vld=%b sel=%h err=%b, want pop=%b vld=%b sel=%h err=%b",
             name, $time, o.pop, o.vld, o.sel, o.err, e.pop, e.vld, e.sel, e.err);
  endfunction

  // One clock: apply inputs, predict, sample at negedge, advance the model.
  task automatic step(input logic [4:0] v, input logic [4:0] t,
                      input logic [4:0][2:0] r, input logic [4:0] rdy,
                      output smp_t obs, output smp_t expv);
    int win [5];
    bit xf  [5];
    in_valid_i  = v;
    in_tail_i   = t;
    req_port_i  = r;
    out_ready_i = rdy;
    expv     = '0;
    expv.err = m_err;
    for (int o = 0; o < 5; o++) begin
      win[o] = -1;
      if (m_owner[o] >= 0) begin
        win[o] = m_owner[o];
      end else begin
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (m_rr[o] + k) % 5;
          if (win[o] < 0 && m_dest[i] < 0 && v[i] && int'(r[i]) == o) win[o] = i;
        end
      end
      xf[o] = (win[o] >= 0) && v[win[o]] && rdy[o];
      if (xf[o]) begin
        expv.pop[win[o]] = 1'b1;
        expv.vld[o]      = 1'b1;
        expv.sel[o]      = 3'(win[o]);
      end
    end
    @(negedge clk_i);
    obs.pop = in_pop_o;
    obs.vld = out_valid_o;
    obs.sel = out_sel_o;
    obs.err = err_o;
    for (int i = 0; i < 5; i++) begin
      if (m_dest[i] < 0 && v[i] && r[i] >= 3'd5) m_err = 1'b1;
    end
    for (int o = 0; o < 5; o++) begin
      if (xf[o]) begin
        if (m_owner[o] < 0) begin
          m_rr[o] = (win[o] + 1) % 5;
          if (!t[win[o]]) begin
            m_owner[o]     = win[o];
            m_dest[win[o]] = o;
          end
        end else if (t[win[o]]) begin
          m_owner[o]     = -1;
          m_dest[win[o]] = -1;
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i     = 1'b0;
    in_valid_i  = '0;
    in_tail_i   = '0;
    req_port_i  = '0;
    out_ready_i = '0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    rst_n_i     = 1'b0;
    in_valid_i  = 5'b11111;
    in_tail_i   = 5'b11111;
    req_port_i  = {E, E, E, E, E};
    out_ready_i = 5'b11111;
    #2;
    n_vec++;
    if ({in_pop_o, out_valid_o, out_sel_o, err_o} !== '0) begin
      n_err++;
      $display("FAIL reset: got pop=%b vld=%b sel=%h err=%b, want all zero",
               in_pop_o, out_valid_o, out_sel_o, err_o);
    end
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_single_flit();
    smp_t o, e;
    logic [4:0][2:0] r;
    r = '0;
    r[0] = E;
    step(5'b00001, 5'b00001, r, 5'b11111, o, e);
    n_vec++;
    if (o !== e) begin n_err++; report("single_flit_model", o, e); end
    n_vec++;
    if (o.pop !== 5'b00001 || o.vld !== 5'b00100 || o.sel[2] !== 3'd0) begin
      n_err++;
      $display("FAIL single_flit: got pop=%b vld=%b sel_e=%0d, want pop=00001 vld=00100 sel_e=0",
               o.pop, o.vld, o.sel[2]);
    end
    // E stays unlocked with its pointer past N, so S now beats N.
    r[1] = E;
    step(5'b00011, 5'b00011, r, 5'b11111, o, e);
    n_vec++;
    if (o !== e) begin n_err++; report("rr_after_single_model", o, e); end
    n_vec++;
    if (o.pop !== 5'b00010 || o.sel[2] !== 3'd1) begin
      n_err++;
      $display("FAIL rr_after_single: got pop=%b sel_e=%0d, want pop=00010 sel_e=1", o.pop, o.sel[2]);
    end
  endtask

  task automatic test_lock_stall();
    smp_t o, e;
    logic [4:0][2:0] r;
    logic [4:0] want;
    do_reset();
    r = '0;
    r[0] = E;
    r[1] = E;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) r[0] = W;  // body flits carry stale routing; must be ignored
      want = (c < 5) ? 5'b00001 : 5'b00010;
      step((c < 5) ? 5'b00011 : 5'b00010, (c == 4) ? 5'b00001 : 5'b00000, r, 5'b11111, o, e);
      n_vec++;
      if (o !== e) begin n_err++; report("lock_stall_model", o, e); end
      n_vec++;
      if (o.pop !== want || o.vld !== 5'b00100) begin
        n_err++;
        $display("FAIL lock_stall cyc %0d: got pop=%b vld=%b, want pop=%b vld=00100", c, o.pop, o.vld, want);
      end
    end
  endtask

  task automatic test_backpressure();
    smp_t o, e;
    logic [4:0][2:0] r;
    do_reset();
    r = '0;
    r[0] = W;
    step(5'b00001, 5'b00000, r, 5'b11111, o, e);
    n_vec++;
    if (o !== e) begin n_err++; report("bp_head_model", o, e); end
    r[1] = W;
    for (int c = 0; c < 4; c++) begin
      step(5'b00011, 5'b00000, r, 5'b10111, o, e);
      n_vec++;
      if (o.pop !== 5'b00000 || o.vld !== 5'b00000) begin
        n_err++;
        $display("FAIL bp_stall cyc %0d: got pop=%b vld=%b, want 00000/00000", c, o.pop, o.vld);
      end
    end
    step(5'b00011, 5'b00001, r, 5'b11111, o, e);
    n_vec++;
    if (o !== e) begin n_err++; report("bp_resume_model", o, e); end
    n_vec++;
    if (o.pop !== 5'b00001 || o.vld !== 5'b01000 || o.sel[3] !== 3'd0) begin
      n_err++;
      $display("FAIL bp_resume: got pop=%b vld=%b sel_w=%0d, want pop=00001 vld=01000 sel_w=0",
               o.pop, o.vld, o.sel[3]);
    end
  endtask

  task automatic test_rotation();
    smp_t o, e;
    logic [4:0][2:0] r;
    do_reset();
    r = {L, L, L, L, L};
    for (int k = 0; k < 6; k++) begin
      step(5'b11111, 5'b11111, r, 5'b11111, o, e);
      n_vec++;
      if (o.sel[4] !== 3'(k % 5) || o.pop !== (5'b00001 << (k % 5)) || o.vld !== 5'b10000) begin
        n_err++;
        $display("FAIL rotation k=%0d: got sel_l=%0d pop=%b vld=%b, want sel_l=%0d", k, o.sel[4], o.pop, o.vld, k % 5);
      end
    end
  endtask

  task automatic test_parallel();
    smp_t o, e;
    logic [4:0][2:0] r;
    do_reset();
    r = '0;
    r[0] = E;
    r[1] = W;
    step(5'b00011, 5'b00011, r, 5'b11111, o, e);
    n_vec++;
    if (o.pop !== 5'b00011 || o.vld !== 5'b01100 || o.sel[2] !== 3'd0 || o.sel[3] !== 3'd1) begin
      n_err++;
      $display("FAIL parallel: got pop=%b vld=%b sel=%h, want pop=00011 vld=01100", o.pop, o.vld, o.sel);
    end
  endtask

  task automatic test_err_async_reset();
    smp_t o, e;
    logic [4:0][2:0] r;
    do_reset();
    r = '0;
    r[0] = 3'd6;
    step(5'b00001, 5'b00001, r, 5'b11111, o, e);
    n_vec++;
    if (o.pop !== 5'b00000 || o.vld !== 5'b00000 || o.err !== 1'b0) begin
      n_err++;
      $display("FAIL err_req: got pop=%b vld=%b err=%b, want 00000/00000/0", o.pop, o.vld, o.err);
    end
    r = '0;
    r[1] = E;
    step(5'b00010, 5'b00000, r, 5'b11111, o, e);
    n_vec++;
    if (o !== e || o.err !== 1'b1) begin n_err++; report("err_sticky", o, e); end
    // S now owns E mid-packet; drop reset between clock edges.
    rst_n_i = 1'b0;
    #2;
    n_vec++;
    if ({in_pop_o, out_valid_o, out_sel_o, err_o} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got pop=%b vld=%b sel=%h err=%b, want all zero",
               in_pop_o, out_valid_o, out_sel_o, err_o);
    end
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_reset();
    r[1] = W;
    step(5'b00010, 5'b00010, r, 5'b11111, o, e);
    n_vec++;
    if (o !== e || o.vld !== 5'b01000) begin n_err++; report("lock_dropped", o, e); end
  endtask

  task automatic test_random();
    smp_t o, e;
    logic [4:0][2:0] r;
    logic [4:0] v, t, rdy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v   = 5'($urandom);
      t   = 5'($urandom) & 5'($urandom);
      rdy = 5'($urandom) | 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        r[i] = ($urandom_range(0, 79) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      end
      step(v, t, r, rdy, o, e);
      n_vec++;
      if (o !== e) begin n_err++; report("random", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_lock_stall();
    test_backpressure();
    test_rotation();
    test_parallel();
    test_err_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
